// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// One request at a time: req/addr out, gnt/rvalid/rdata back.
interface fetch_stage_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  imem_req;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic                  imem_gnt;
    logic                  imem_rvalid;
    logic [DATA_WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, single-outstanding imem handshake,
// one-entry skid buffer and the F/D pipeline register, with stale-response discard.
module fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            PC_source_E,
    input  logic [DATA_WIDTH-1:0] ALU_result_E,
    input  logic                  stall_D,
    fetch_stage_if.master         imem,
    output logic [DATA_WIDTH-1:0] PC_F,
    output logic [DATA_WIDTH-1:0] instr_D,
    output logic [DATA_WIDTH-1:0] PC_D,
    output logic [DATA_WIDTH-1:0] PC_plus4_D,
    output logic                  valid_D
);

    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {FETCH, WAIT, BUFFERED} state_t;

    state_t                state, state_nxt;
    logic                  drop, drop_nxt;
    logic [DATA_WIDTH-1:0] pc_nxt;
    logic [DATA_WIDTH-1:0] buf_instr, buf_pc;
    logic                  redirect, fd_free, fd_load, buf_load;
    logic [DATA_WIDTH-1:0] fd_instr, fd_pc;

    function automatic logic [DATA_WIDTH-1:0] pc_inc(input logic [DATA_WIDTH-1:0] pc);
        return pc + DATA_WIDTH'(4);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] word_align(input logic [DATA_WIDTH-1:0] addr);
        return addr & ~DATA_WIDTH'(3);
    endfunction

    // 2'b11 is reserved and behaves as sequential fetch
    assign redirect = (PC_source_E == 2'b01) || (PC_source_E == 2'b10);
    assign fd_free  = !valid_D || !stall_D;

    assign imem.imem_req  = (state == FETCH) && !rst;
    assign imem.imem_addr = PC_F;

    always_comb begin
        state_nxt = state;
        drop_nxt  = drop;
        pc_nxt    = PC_F;
        fd_load   = 1'b0;
        buf_load  = 1'b0;
        fd_instr  = imem.imem_rdata;
        fd_pc     = PC_F;
        if (redirect) begin
            pc_nxt = word_align(ALU_result_E);
            // An accepted request with no response yet must have its response swallowed
            if ((state == WAIT && !imem.imem_rvalid) || (state == FETCH && imem.imem_gnt)) begin
                drop_nxt  = 1'b1;
                state_nxt = WAIT;
            end else begin
                drop_nxt  = 1'b0;
                state_nxt = FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (imem.imem_gnt) state_nxt = WAIT;
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        state_nxt = FETCH;
                        if (drop) begin
                            drop_nxt = 1'b0;
                        end else begin
                            pc_nxt = pc_inc(PC_F);
                            if (fd_free) begin
                                fd_load = 1'b1;
                            end else begin
                                buf_load  = 1'b1;
                                state_nxt = BUFFERED;
                            end
                        end
                    end
                end
                BUFFERED: begin
                    if (!stall_D) begin
                        fd_load   = 1'b1;
                        fd_instr  = buf_instr;
                        fd_pc     = buf_pc;
                        state_nxt = FETCH;
                    end
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            drop  <= 1'b0;
            PC_F  <= RESET_PC;
        end else begin
            state <= state_nxt;
            drop  <= drop_nxt;
            PC_F  <= pc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_load) begin
            buf_instr <= imem.imem_rdata;
            buf_pc    <= PC_F;
        end
    end

    // F/D register: a redirect squashes it even under stall
    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            valid_D    <= 1'b0;
            instr_D    <= NOP;
            PC_D       <= '0;
            PC_plus4_D <= '0;
        end else if (fd_load) begin
            valid_D    <= 1'b1;
            instr_D    <= fd_instr;
            PC_D       <= fd_pc;
            PC_plus4_D <= pc_inc(fd_pc);
        end else if (!stall_D) begin
            valid_D    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a memory responder feeds the main DUT,
// a second instance with RESET_PC at the top of the address space covers wrap-around.
module tb_fetch_stage;

    localparam int          W   = 32;
    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } fd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] alu = 32'h0;
    logic        stall = 1'b0;

    logic [31:0] pc_f, instr_d, pc_d, pc4_d;
    logic        valid_d;
    logic [31:0] pc_f_h, instr_d_h, pc_d_h, pc4_d_h;
    logic        valid_d_h;

    fetch_stage_if #(.DATA_WIDTH(W)) bus ();
    fetch_stage_if #(.DATA_WIDTH(W)) bus_hi ();

    fetch_stage #(.DATA_WIDTH(W), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst), .PC_source_E(pc_src), .ALU_result_E(alu), .stall_D(stall),
        .imem(bus), .PC_F(pc_f), .instr_D(instr_d), .PC_D(pc_d), .PC_plus4_D(pc4_d),
        .valid_D(valid_d)
    );

    fetch_stage #(.DATA_WIDTH(W), .RESET_PC(32'hFFFF_FFFC)) u_dut_hi (
        .clk(clk), .rst(rst), .PC_source_E(pc_src), .ALU_result_E(alu), .stall_D(stall),
        .imem(bus_hi), .PC_F(pc_f_h), .instr_D(instr_d_h), .PC_D(pc_d_h), .PC_plus4_D(pc4_d_h),
        .valid_D(valid_d_h)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          grant_limit = 0;
    int          lat = 1;
    logic [31:0] dead_addr = 32'h0000_0001;
    logic [31:0] fired_q[$];
    fd_t         sb[$];
    fd_t         obs[$];
    int          cmp_idx = 0;

    // memory responder state
    logic        m_fire, m_pend;
    logic [31:0] m_a, m_paddr;
    int          m_cnt;

    // monitor state
    logic        mon_pv, mon_ps;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_fire(input int n);
        int c = 0;
        while (fired_q.size() < n && c < 60) begin
            tick();
            c++;
        end
        chk("fire_count", fired_q.size(), n);
    endtask

    task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc);
        fd_t e;
        e.instr = instr;
        e.pc    = pc;
        e.pc4   = pc + 32'd4;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        int c = 0;
        while (obs.size() < sb.size() && c < 80) begin
            tick();
            c++;
        end
        chk({tag, "_entries"}, obs.size(), sb.size());
        while (cmp_idx < sb.size() && cmp_idx < obs.size()) begin
            chk({tag, "_instr"}, obs[cmp_idx].instr, sb[cmp_idx].instr);
            chk({tag, "_pc"}, obs[cmp_idx].pc, sb[cmp_idx].pc);
            chk({tag, "_pc4"}, obs[cmp_idx].pc4, sb[cmp_idx].pc4);
            cmp_idx++;
        end
    endtask

    // Memory: grants up to grant_limit requests, answers each after lat cycles
    initial begin
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        m_pend = 1'b0;
        m_paddr = 32'h0;
        m_cnt = 0;
        forever begin
            @(negedge clk);
            m_fire = bus.imem_req && bus.imem_gnt;
            m_a    = bus.imem_addr;
            @(posedge clk);
            #1;
            bus.imem_rvalid = 1'b0;
            if (m_fire) begin
                m_pend  = 1'b1;
                m_paddr = m_a;
                m_cnt   = lat;
                fired_q.push_back(m_a);
            end
            if (m_pend) begin
                if (m_cnt <= 1) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = (m_paddr == dead_addr) ? 32'hDEAD_BEEF : (m_paddr ^ KEY);
                    m_pend = 1'b0;
                end else begin
                    m_cnt--;
                end
            end
            bus.imem_gnt = (fired_q.size() < grant_limit);
        end
    end

    // Records each new F/D entry presented to decode
    initial begin
        mon_pv = 1'b0;
        mon_ps = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_pv = 1'b0;
                mon_ps = 1'b0;
            end else begin
                if (valid_d && (!mon_pv || !mon_ps)) obs.push_back('{instr_d, pc_d, pc4_d});
                mon_pv = valid_d;
                mon_ps = stall;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_hi.imem_gnt    = 1'b0;
        bus_hi.imem_rvalid = 1'b0;
        bus_hi.imem_rdata  = 32'h0;

        // reset state
        tick();
        tick();
        @(negedge clk);
        chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
        chk("rst_valid", {31'b0, valid_d}, 32'd0);
        chk("rst_instr", instr_d, NOP);
        chk("rst_pc_d", pc_d, 32'h0);
        chk("rst_pc4_d", pc4_d, 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);

        // sequential zero-wait fetch of 0,4,8
        tick();
        rst = 1'b0;
        lat = 1;
        for (int i = 0; i < 3; i++) push_exp((32'(i) * 4) ^ KEY, 32'(i) * 4);
        grant_limit = 3;
        wait_fire(3);
        drain("seq");
        for (int i = 0; i < 3; i++) chk("seq_addr", fired_q[i], 32'(i) * 4);
        tick();
        @(negedge clk);
        chk("seq_bubble", {31'b0, valid_d}, 32'd0);
        chk("seq_next_addr", bus.imem_addr, 32'd12);
        chk("seq_req", {31'b0, bus.imem_req}, 32'd1);

        // decode stalled while a second response arrives: skid buffer
        tick();
        stall = 1'b1;
        dead_addr = 32'd16;
        push_exp(32'd12 ^ KEY, 32'd12);
        push_exp(32'hDEAD_BEEF, 32'd16);
        grant_limit = 5;
        wait_fire(5);
        repeat (3) tick();
        @(negedge clk);
        chk("buf_entries", obs.size(), 4);
        chk("buf_hold_pc", pc_d, 32'd12);
        chk("buf_hold_valid", {31'b0, valid_d}, 32'd1);
        chk("buf_req", {31'b0, bus.imem_req}, 32'd0);
        chk("buf_pc_f", bus.imem_addr, 32'd20);
        tick();
        stall = 1'b0;
        tick();
        stall = 1'b1;
        @(negedge clk);
        chk("buf_out_instr", instr_d, 32'hDEAD_BEEF);
        chk("buf_out_valid", {31'b0, valid_d}, 32'd1);
        drain("buf");

        // branch redirect from FETCH while F/D is stalled and valid
        tick();
        pc_src = 2'b01;
        alu = 32'h0000_0103;
        tick();
        pc_src = 2'b00;
        stall = 1'b0;
        @(negedge clk);
        chk("br_addr", bus.imem_addr, 32'h0000_0100);
        chk("br_valid", {31'b0, valid_d}, 32'd0);
        chk("br_instr", instr_d, NOP);
        push_exp(32'h100 ^ KEY, 32'h100);
        grant_limit = 6;
        wait_fire(6);
        drain("br");
        chk("br_fired", fired_q[5], 32'h100);

        // jump redirect while WAITing on a slow response: stale data dropped
        lat = 3;
        push_exp(32'h200 ^ KEY, 32'h200);
        grant_limit = 8;
        wait_fire(7);
        pc_src = 2'b10;
        alu = 32'h0000_0200;
        tick();
        pc_src = 2'b00;
        @(negedge clk);
        chk("jal_req", {31'b0, bus.imem_req}, 32'd0);
        chk("jal_pc_f", bus.imem_addr, 32'h200);
        chk("jal_valid", {31'b0, valid_d}, 32'd0);
        wait_fire(8);
        drain("jal");
        chk("jal_stale_addr", fired_q[6], 32'h104);
        chk("jal_new_addr", fired_q[7], 32'h200);

        // reset during WAIT; the late response must be ignored
        lat = 2;
        grant_limit = 9;
        wait_fire(9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rstw_valid", {31'b0, valid_d}, 32'd0);
        chk("rstw_instr", instr_d, NOP);
        chk("rstw_addr", bus.imem_addr, 32'h0);
        chk("rstw_req", {31'b0, bus.imem_req}, 32'd1);

        // reserved PC source behaves as sequential
        tick();
        pc_src = 2'b11;
        alu = 32'h0000_0500;
        tick();
        pc_src = 2'b00;
        @(negedge clk);
        chk("rsv_addr", bus.imem_addr, 32'h0);

        // second instance: PC wraps past the top of the address space
        chk("wrap_rst_addr", bus_hi.imem_addr, 32'hFFFF_FFFC);
        chk("wrap_rst_req", {31'b0, bus_hi.imem_req}, 32'd1);
        tick();
        bus_hi.imem_gnt = 1'b1;
        tick();
        bus_hi.imem_gnt    = 1'b0;
        bus_hi.imem_rvalid = 1'b1;
        bus_hi.imem_rdata  = 32'h1234_5678;
        tick();
        bus_hi.imem_rvalid = 1'b0;
        @(negedge clk);
        chk("wrap_pc_d", pc_d_h, 32'hFFFF_FFFC);
        chk("wrap_pc4_d", pc4_d_h, 32'h0);
        chk("wrap_instr", instr_d_h, 32'h1234_5678);
        chk("wrap_valid", {31'b0, valid_d_h}, 32'd1);
        chk("wrap_next_addr", bus_hi.imem_addr, 32'h0);

        repeat (4) tick();
        chk("final_entries", obs.size(), sb.size());
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the RV32I pipeline. Consumes the execute stage's redirect outputs (PC source select, branch/jump target) and produces the F/D pipeline register contents (instruction, PC, PC+4, valid) for the decode stage. Owns the PC register and a single-outstanding-request instruction-memory handshake, with discard of stale responses after a redirect.

Parameters:
DATA_WIDTH, 32, width of PC, target and instruction words
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
PC_source_E  in  2  00 sequential, 01 branch redirect, 10 jump redirect, 11 reserved (treated as 00)
ALU_result_E  in  DATA_WIDTH  redirect target from execute
stall_D  in  1  decode cannot accept; hold F/D register
imem_req  out  1  request valid
imem_addr  out  DATA_WIDTH  request address (= PC_F)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response data valid
imem_rdata  in  DATA_WIDTH  response instruction word
PC_F  out  DATA_WIDTH  current fetch PC
instr_D  out  DATA_WIDTH  F/D instruction
PC_D  out  DATA_WIDTH  F/D PC
PC_plus4_D  out  DATA_WIDTH  F/D PC+4
valid_D  out  1  F/D entry holds a real instruction

Behaviour:
- Reset (rst=1 at edge): PC_F=RESET_PC; state=FETCH; valid_D=0; instr_D=32'h0000_0013 (NOP); PC_D=0; PC_plus4_D=0; drop flag=0; buffer empty. imem_req=0 during the reset cycle. Reset mid-transaction aborts it; a late rvalid arriving after reset is ignored (drop flag logic not used; state FETCH does not accept rvalid).
- States: FETCH (imem_req=1, imem_addr=PC_F), WAIT (request accepted, awaiting rvalid; imem_req=0), BUFFERED (response held in one-entry skid buffer because F/D stalled; imem_req=0).
- FETCH -> WAIT when imem_gnt=1. Otherwise stay; imem_addr stable while imem_req=1 and no redirect.
- WAIT, imem_rvalid=1, drop=0: if F/D free (valid_D=0 or stall_D=0) load instr_D=imem_rdata, PC_D=PC_F, PC_plus4_D=PC_F+4, valid_D=1, PC_F<=PC_F+4, -> FETCH. Else store rdata/PC in buffer, PC_F<=PC_F+4, -> BUFFERED.
- WAIT, imem_rvalid=1, drop=1: discard data, drop<=0, -> FETCH. PC_F unchanged.
- BUFFERED -> FETCH when stall_D=0: buffer moves to F/D (valid_D=1).
- F/D consumed: stall_D=0 and no new load -> valid_D<=0 (bubble).
- stall_D=1: instr_D/PC_D/PC_plus4_D/valid_D hold.
- Redirect (PC_source_E=01 or 10) has priority over everything except rst: PC_F<={ALU_result_E[DATA_WIDTH-1:2],2'b00}; valid_D<=0 and F/D contents set to NOP even if stall_D=1; buffer cleared. If in WAIT without rvalid this cycle, or in FETCH with imem_gnt=1 this cycle: drop<=1, next state WAIT. If in WAIT with rvalid this cycle: response discarded, -> FETCH. Otherwise -> FETCH.
- Latency: redirect in cycle N -> imem_addr=target in cycle N+1 (assuming no stale response pending). Zero-wait memory (gnt and rvalid next cycle): one instruction per 2 cycles; valid_D rises the edge after rvalid.
- PC+4 wraps modulo 2^DATA_WIDTH (32'hFFFF_FFFC+4=0).
- At most one request outstanding; imem_req never asserted in WAIT or BUFFERED.

Test Plan:
- Reset, gnt=1 always, rvalid one cycle after gnt, rdata=addr^32'hA5A5_0000 -> imem_addr sequence 0,4,8; PC_D 0,4,8 with PC_plus4_D 4,8,12; instr_D matches; valid_D pulses.
- Redirect PC_source_E=01, ALU_result_E=32'h0000_0103 while in FETCH -> next imem_addr=32'h0000_0100; valid_D=0 next cycle; instr_D=32'h0000_0013.
- Redirect 10 to 32'h200 in WAIT, rvalid delayed 3 cycles -> stale rdata discarded, no valid_D, then imem_addr=32'h200, PC_D=32'h200 after response.
- stall_D=1 with valid_D=1 when rvalid arrives (rdata=32'hDEAD_BEEF) -> F/D held, state BUFFERED, imem_req=0; stall_D=0 -> instr_D=32'hDEAD_BEEF, valid_D=1 next edge.
- RESET_PC=32'hFFFF_FFFC -> first fetch PC_D=32'hFFFF_FFFC, PC_plus4_D=0, next imem_addr=0.
- rst asserted in WAIT, rvalid arrives cycle after -> response ignored, valid_D=0, imem_addr=RESET_PC.
